alu_seq: RTL and testbench

Parametrised, clocked successor to the SAP-1 combinational adder/subtractor. Registers its result and a four-bit flag set, adds carry-chained and logic operations, and performs a multi-cycle shift-add multiply behind a start/busy/done handshake. Sits between the A/B registers and the shared bus; the result reaches the bus only while `sum_wr` is high.

---
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU for the SAP-1 datapath: single-cycle add/sub/logic ops with flags,
// plus a WIDTH-cycle shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             sum_wr,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic             carry_flg,
  output logic             zero_flg,
  output logic             neg_flg,
  output logic             ovf_flg
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_ADC = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_MUL = 3'd7;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   result;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   b_x, alu_res;
  logic [WIDTH:0]     sum;
  logic               cin, alu_c, alu_v, last;

  always_comb begin
    b_x     = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    cin     = 1'b0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = carry_flg;
      default:        cin = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      default: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        // signed overflow: like-signed operands producing a differently-signed result
        alu_v   = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign last    = (count == CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && op == OP_MUL) state_nxt = MUL;
      MUL:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      result    <= '0;
      carry_flg <= 1'b0;
      zero_flg  <= 1'b0;
      neg_flg   <= 1'b0;
      ovf_flg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= CW'(WIDTH);
            busy   <= 1'b1;
          end else begin
            result    <= alu_res;
            carry_flg <= alu_c;
            ovf_flg   <= alu_v;
            zero_flg  <= (alu_res == '0);
            neg_flg   <= alu_res[WIDTH-1];
            done      <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (last) begin
            result    <= acc_nxt[WIDTH-1:0];
            carry_flg <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_flg   <= |acc_nxt[2*WIDTH-1:WIDTH];
            zero_flg  <= (acc_nxt[WIDTH-1:0] == '0);
            neg_flg   <= acc_nxt[WIDTH-1];
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the committed result register ever reaches the bus.
  assign bus = sum_wr ? result : 'z;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 and WIDTH=16 instances, an arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n, sum_wr, st8, st16;
  logic [2:0]  op;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  wire  [7:0]  bus8;
  wire  [15:0] bus16;
  wire  [1:0]  busy_w, done_w;
  wire  [1:0][3:0] flg_w;   // {c,z,n,v}

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .a(a8), .b(b8), .op(op), .start(st8), .sum_wr(sum_wr),
    .bus(bus8), .busy(busy_w[0]), .done(done_w[0]),
    .carry_flg(flg_w[0][3]), .zero_flg(flg_w[0][2]), .neg_flg(flg_w[0][1]), .ovf_flg(flg_w[0][0]));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .clr_n(clr_n), .a(a16), .b(b16), .op(op), .start(st16), .sum_wr(sum_wr),
    .bus(bus16), .busy(busy_w[1]), .done(done_w[1]),
    .carry_flg(flg_w[1][3]), .zero_flg(flg_w[1][2]), .neg_flg(flg_w[1][1]), .ovf_flg(flg_w[1][0]));

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
  } res_t;

  function automatic longint sx(longint x, int w);
    return (x >= (64'sd1 <<< (w - 1))) ? x - (64'sd1 <<< w) : x;
  endfunction

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_alu(int w, logic [2:0] o, longint x, longint y, logic cin);
    longint mask = (64'sd1 <<< w) - 1;
    longint yi   = (~y) & mask;
    longint s    = 0;
    longint ss   = 0;
    logic   c = 0, v = 0;
    res_t   t;
    case (o)
      3'd0: begin s = x + y;             ss = sx(x, w) + sx(y, w);             end
      3'd1: begin s = x + yi + 1;        ss = sx(x, w) + sx(yi, w) + 1;        end
      3'd2: begin s = x + y + cin;       ss = sx(x, w) + sx(y, w) + cin;       end
      3'd3: begin s = x + yi + cin;      ss = sx(x, w) + sx(yi, w) + cin;      end
      3'd4: s = x & y;
      3'd5: s = x | y;
      3'd6: s = x ^ y;
      default: s = x * y;
    endcase
    if (o <= 3'd3) begin
      c = ((s >> w) & 1) != 0;
      v = (ss > (mask >> 1)) || (ss < -((mask >> 1) + 1));
    end else if (o == 3'd7) begin
      c = (s >> w) != 0;
      v = c;
    end
    t.r = 16'(s & mask);
    t.f = {c, (s & mask) == 0, ((s >> (w - 1)) & 1) != 0, v};
    return t;
  endfunction

  function automatic int wof(int k);   return (k == 0) ? 8 : 16; endfunction
  function automatic longint av(int k); return (k == 0) ? longint'(a8) : longint'(a16); endfunction
  function automatic longint bv(int k); return (k == 0) ? longint'(b8) : longint'(b16); endfunction
  function automatic logic stv(int k);  return (k == 0) ? st8 : st16; endfunction
  function automatic longint busv(int k); return (k == 0) ? longint'(bus8) : longint'(bus16); endfunction

  res_t m_res[2], m_pend[2];
  logic m_busy[2], m_done[2];
  int   m_left[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!clr_n) begin
        m_res[k] <= '0; m_busy[k] <= 0; m_done[k] <= 0; m_left[k] <= 0;
      end else if (m_left[k] != 0) begin
        m_left[k] <= m_left[k] - 1;
        m_done[k] <= (m_left[k] == 1);
        m_busy[k] <= (m_left[k] != 1);
        if (m_left[k] == 1) m_res[k] <= m_pend[k];
      end else if (stv(k)) begin
        if (op == 3'd7) begin
          m_left[k] <= wof(k);
          m_pend[k] <= ref_alu(wof(k), op, av(k), bv(k), 1'b0);
          m_busy[k] <= 1; m_done[k] <= 0;
        end else begin
          m_res[k]  <= ref_alu(wof(k), op, av(k), bv(k), m_res[k].f[3]);
          m_done[k] <= 1;
        end
      end else begin
        m_done[k] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (sum_wr && busv(k) !== longint'(m_res[k].r)) begin
          errors++; $display("FAIL model_bus[%0d] got %h want %h", k, busv(k), m_res[k].r);
        end
        checks++;
        if (flg_w[k] !== m_res[k].f) begin
          errors++; $display("FAIL model_flags[%0d] got %b want %b", k, flg_w[k], m_res[k].f);
        end
        checks++;
        if (busy_w[k] !== m_busy[k] || done_w[k] !== m_done[k]) begin
          errors++;
          $display("FAIL model_hs[%0d] got busy=%b done=%b want busy=%b done=%b",
                   k, busy_w[k], done_w[k], m_busy[k], m_done[k]);
        end
      end
    end
  end

  task automatic lit(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input int k, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    op = o;
    if (k == 0) begin a8 = x[7:0]; b8 = y[7:0]; st8 = 1; end
    else        begin a16 = x;     b16 = y;     st16 = 1; end
    @(negedge clk);
    st8 = 0; st16 = 0;
  endtask

  task automatic wait_done(input int k, output int cyc);
    cyc = 0;
    while (done_w[k] !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 64) lit("done_timeout", cyc, 0);
  endtask

  task automatic expect_res(input string name, input int k, input longint r, input logic [3:0] f);
    lit({name, "_res"}, busv(k), r);
    lit({name, "_flg"}, longint'(flg_w[k]), longint'(f));
  endtask

  int cyc;
  logic zok;

  initial begin
    clr_n = 0; sum_wr = 1; st8 = 0; st16 = 0; op = 0;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    @(negedge clk);
    armed = 1;
    @(negedge clk);
    clr_n = 1;
    expect_res("reset8", 0, 0, 4'b0000);
    lit("reset_hs", {busy_w, done_w}, 0);

    issue(0, 3'd0, 16'hFC, 16'h05);  expect_res("add_fc05", 0, 8'h01, 4'b1000);
    lit("add_done", done_w[0], 1);
    @(negedge clk);                  lit("add_done_drop", done_w[0], 0);
    issue(0, 3'd0, 16'h7F, 16'h01);  expect_res("add_7f01", 0, 8'h80, 4'b0011);
    issue(0, 3'd1, 16'h08, 16'h08);  expect_res("sub_eq", 0, 8'h00, 4'b1100);
    issue(0, 3'd1, 16'h08, 16'h09);  expect_res("sub_brw", 0, 8'hFF, 4'b0010);
    issue(0, 3'd0, 16'hFF, 16'h01);  expect_res("add_ff01", 0, 8'h00, 4'b1100);
    issue(0, 3'd2, 16'h00, 16'h00);  expect_res("adc_chain", 0, 8'h01, 4'b0000);
    issue(0, 3'd3, 16'h05, 16'h05);  expect_res("sbc_c0", 0, 8'hFF, 4'b0010);
    issue(0, 3'd6, 16'h5A, 16'hFF);  expect_res("xor", 0, 8'hA5, 4'b0010);

    issue(0, 3'd7, 16'h0C, 16'h0B);
    lit("mul_busy", busy_w[0], 1);
    wait_done(0, cyc);
    lit("mul_latency8", cyc, 8);
    expect_res("mul_0c0b", 0, 8'h84, 4'b0010);

    sum_wr = 0;
    #1 zok = $isunknown(bus8) || (bus8 == 8'h00);
    lit("bus_hiz", zok, 1);
    @(negedge clk);
    sum_wr = 1;

    issue(0, 3'd7, 16'h10, 16'h10);
    @(negedge clk); @(negedge clk);
    issue(0, 3'd0, 16'h01, 16'h01);  // ignored while multiplying
    wait_done(0, cyc);
    expect_res("mul_1010", 0, 8'h00, 4'b1101);

    issue(0, 3'd7, 16'h0C, 16'h0B);
    @(negedge clk); @(negedge clk);
    clr_n = 0;
    @(negedge clk);
    clr_n = 1;
    expect_res("mul_abort", 0, 0, 4'b0000);
    lit("abort_hs", {busy_w[0], done_w[0]}, 0);
    repeat (12) @(negedge clk);

    issue(1, 3'd7, 16'h00FF, 16'h0101);
    wait_done(1, cyc);
    lit("mul_latency16", cyc, 16);
    expect_res("mul16", 1, 16'hFFFF, 4'b0010);
    issue(1, 3'd4, 16'hF0F0, 16'h0FF0);  expect_res("and16", 1, 16'h00F0, 4'b0000);
    issue(1, 3'd1, 16'h8000, 16'h0001);  expect_res("sub16_ovf", 1, 16'h7FFF, 4'b1001);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
